// File: rtl/mmio_timer_responder_if.sv
`timescale 1ns/1ps
// CPU data-memory bus as seen by the peripheral responder.
// The CPU drives the access in EX; the responder returns registered read data for MEM.
interface mmio_timer_responder_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] rdata;

  modport master (output addr, output wdata, output mem_read, output mem_write, input rdata);
  modport slave  (input addr, input wdata, input mem_read, input mem_write, output rdata);
endinterface

// File: rtl/mmio_timer_responder.sv
`timescale 1ns/1ps
// Six-word MMIO window: reload timer (TH/TL/TCON), LED, 7-segment register and
// a free-running system tick. Read data is registered; irq mirrors TCON[2].
module mmio_timer_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
  input  logic                   clk,
  input  logic                   reset,
  mmio_timer_responder_if.slave  bus,
  output logic                   irq,
  output logic [7:0]             led,
  output logic [11:0]            digi
);

  logic [31:0] th;
  logic [31:0] tl;
  logic [2:0]  tcon;
  logic [31:0] systick;

  logic [2:0]  offset;
  logic        hit;
  logic        wr_en;
  logic        overflow;
  logic [31:0] rd_val;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^bus.addr[1:0];

  // BASE_ADDR is 32-byte aligned, so the window is one 8-word block with 6 live words.
  assign offset   = bus.addr[4:2];
  assign hit      = (bus.addr[31:5] == BASE_ADDR[31:5]) && (offset <= 3'd5);
  assign wr_en    = bus.mem_write && hit;
  assign overflow = tcon[0] && (tl == 32'hFFFF_FFFF);
  assign irq      = tcon[2];

  always_comb begin
    rd_val = 32'd0;
    if (hit) begin
      case (offset)
        3'd0:    rd_val = th;
        3'd1:    rd_val = tl;
        3'd2:    rd_val = {29'd0, tcon};
        3'd3:    rd_val = {24'd0, led};
        3'd4:    rd_val = {20'd0, digi};
        3'd5:    rd_val = systick;
        default: rd_val = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th        <= 32'd0;
      tl        <= 32'd0;
      tcon      <= 3'd0;
      led       <= 8'd0;
      digi      <= 12'd0;
      systick   <= 32'd0;
      bus.rdata <= 32'd0;
    end else begin
      systick   <= systick + 32'd1;
      bus.rdata <= bus.mem_read ? rd_val : 32'd0;

      if (wr_en && offset == 3'd0) th <= bus.wdata;

      // A bus write to TL beats counting and reload; reload uses the pre-edge TH.
      if (wr_en && offset == 3'd1)  tl <= bus.wdata;
      else if (overflow)            tl <= th;
      else if (tcon[0])             tl <= tl + 32'd1;

      // An overflow set of the status bit wins over a same-edge software clear.
      if (wr_en && offset == 3'd2) begin
        tcon[1:0] <= bus.wdata[1:0];
        tcon[2]   <= bus.wdata[2] | (overflow & tcon[1]);
      end else begin
        tcon[2]   <= tcon[2] | (overflow & tcon[1]);
      end

      if (wr_en && offset == 3'd3) led  <= bus.wdata[7:0];
      if (wr_en && offset == 3'd4) digi <= bus.wdata[11:0];
    end
  end

endmodule

// File: tb/tb_mmio_timer_responder.sv
`timescale 1ns/1ps
// Directed bench for mmio_timer_responder: reset, systick, timer overflow/reload,
// clear-versus-set race, same-cycle access, LED/DIGI, unmapped window and disable.
module tb_mmio_timer_responder;
  localparam logic [31:0] BASE  = 32'h4000_0000;
  localparam logic [31:0] O_TH  = 32'd0;
  localparam logic [31:0] O_TL  = 32'd4;
  localparam logic [31:0] O_TC  = 32'd8;
  localparam logic [31:0] O_LED = 32'd12;
  localparam logic [31:0] O_DG  = 32'd16;
  localparam logic [31:0] O_ST  = 32'd20;
  localparam logic [31:0] O_UNM = 32'd24;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        irq;
  logic [7:0]  led;
  logic [11:0] digi;
  logic [31:0] d;
  int          n_chk = 0;
  int          n_bad = 0;

  mmio_timer_responder_if bus();

  mmio_timer_responder #(.BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .irq   (irq),
    .led   (led),
    .digi  (digi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] data);
    bus.addr = BASE + off; bus.wdata = data; bus.mem_write = 1'b1;
    tick();
    bus.mem_write = 1'b0;
  endtask

  task automatic rd(input logic [31:0] off, output logic [31:0] data);
    bus.addr = BASE + off; bus.mem_read = 1'b1;
    tick();
    bus.mem_read = 1'b0;
    data = bus.rdata;
  endtask

  task automatic rw(input logic [31:0] off, input logic [31:0] wd, output logic [31:0] data);
    bus.addr = BASE + off; bus.wdata = wd; bus.mem_read = 1'b1; bus.mem_write = 1'b1;
    tick();
    bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    data = bus.rdata;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", n_chk, n_bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    bus.addr = 32'd0; bus.wdata = 32'd0; bus.mem_read = 1'b0; bus.mem_write = 1'b0;

    // Reset state and systick counting from 0
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_led", {24'd0, led}, 32'd0);
    chk("rst_digi", {20'd0, digi}, 32'd0);
    reset = 1'b0;
    repeat (10) tick();
    rd(O_ST, d);      chk("systick_10", d, 32'd10);
    tick();           chk("rdata_idle_zero", bus.rdata, 32'd0);

    // Timer overflow, reload and period
    wr(O_TH, 32'hFFFF_FFF0);
    wr(O_TL, 32'hFFFF_FFFC);
    wr(O_TC, 32'h0000_0003);
    chk("irq_after_tcon_wr", {31'd0, irq}, 32'd0);
    repeat (3) tick();
    chk("irq_before_ovf", {31'd0, irq}, 32'd0);
    tick();
    chk("irq_at_ovf", {31'd0, irq}, 32'd1);
    rd(O_TL, d);      chk("tl_reload", d, 32'hFFFF_FFF0);
    wr(O_TC, 32'h0000_0003);
    chk("irq_cleared", {31'd0, irq}, 32'd0);
    repeat (13) tick();
    chk("irq_before_ovf2", {31'd0, irq}, 32'd0);
    tick();
    chk("irq_at_ovf2", {31'd0, irq}, 32'd1);

    // Software clear in the overflow cycle loses to the set
    wr(O_TC, 32'h0000_0003);
    chk("irq_clear2", {31'd0, irq}, 32'd0);
    wr(O_TL, 32'hFFFF_FFFE);
    tick();
    wr(O_TC, 32'h0000_0003);
    chk("race_irq", {31'd0, irq}, 32'd1);
    rd(O_TC, d);      chk("race_tcon", d, 32'h0000_0007);
    chk("race_irq_hold", {31'd0, irq}, 32'd1);

    // Same-cycle read/write and write-versus-count
    wr(O_TC, 32'h0000_0000);
    chk("irq_off", {31'd0, irq}, 32'd0);
    wr(O_TL, 32'h0000_ABCD);
    rw(O_TL, 32'h1234_5678, d); chk("rw_old_tl", d, 32'h0000_ABCD);
    rd(O_TL, d);      chk("rw_new_tl", d, 32'h1234_5678);
    wr(O_TC, 32'h0000_0001);
    wr(O_TL, 32'hCAFE_0000);
    rd(O_TL, d);      chk("wr_beats_count", d, 32'hCAFE_0000);
    rd(O_TL, d);      chk("count_after_wr", d, 32'hCAFE_0001);

    // LED, DIGI, byte-offset ignored, unmapped word
    wr(O_LED, 32'hFFFF_FFA5);
    chk("led_out", {24'd0, led}, 32'h0000_00A5);
    rd(O_LED + 32'd3, d); chk("led_read", d, 32'h0000_00A5);
    wr(O_DG, 32'h0000_0E3F);
    chk("digi_out", {20'd0, digi}, 32'h0000_0E3F);
    rd(O_DG, d);      chk("digi_read", d, 32'h0000_0E3F);
    wr(O_UNM, 32'hFFFF_FFFF);
    rd(O_UNM, d);     chk("unmapped_read", d, 32'd0);
    chk("unmapped_led", {24'd0, led}, 32'h0000_00A5);
    chk("unmapped_digi", {20'd0, digi}, 32'h0000_0E3F);
    rd(O_TH, d);      chk("unmapped_th", d, 32'hFFFF_FFF0);
    rd(O_TC, d);      chk("unmapped_tcon", d, 32'h0000_0001);

    // Enable off holds TL and never raises irq
    wr(O_TC, 32'h0000_0002);
    wr(O_TL, 32'hFFFF_FFFF);
    repeat (20) tick();
    rd(O_TL, d);      chk("disabled_tl", d, 32'hFFFF_FFFF);
    chk("disabled_irq", {31'd0, irq}, 32'd0);

    // Asynchronous reset mid-count
    wr(O_TC, 32'h0000_0005);
    chk("irq_sw_set", {31'd0, irq}, 32'd1);
    rd(O_TH, d);      chk("pre_reset_rdata", d, 32'hFFFF_FFF0);
    #3 reset = 1'b1;
    #1;
    chk("async_rdata", bus.rdata, 32'd0);
    chk("async_irq", {31'd0, irq}, 32'd0);
    chk("async_led", {24'd0, led}, 32'd0);
    chk("async_digi", {20'd0, digi}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    rd(O_TH, d);      chk("post_rst_th", d, 32'd0);
    rd(O_TL, d);      chk("post_rst_tl", d, 32'd0);
    rd(O_TC, d);      chk("post_rst_tcon", d, 32'd0);
    rd(O_LED, d);     chk("post_rst_led", d, 32'd0);
    rd(O_DG, d);      chk("post_rst_digi", d, 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
